// File: rtl/add_share_pkg.sv
// Shared types and widths for the add_share_ctrl adder-sharing controller.
package add_share_pkg;

  localparam int ADD_W  = 32;
  localparam int WIDE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/add_share_ctrl_rca32.sv
// RCA32: 32-bit ripple-carry adder shared by the add_share_ctrl sequencer.
module RCA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin
    logic [32:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 32; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[32];
  end

endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin controller sharing one RCA32 among NREQ requesters; wide ops take two passes.
// Optional result flags (rsp_ovf, rsp_zero) are enabled by defining ADD_SHARE_FLAGS_EN.
module add_share_ctrl
  import add_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_wide,
  input  logic [NREQ*WIDE_W-1:0] req_a,
  input  logic [NREQ*WIDE_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDE_W-1:0]      rsp_sum,
  output logic                   rsp_cout
`ifdef ADD_SHARE_FLAGS_EN
  ,
  output logic                   rsp_ovf,
  output logic                   rsp_zero
`endif
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      last_grant_q, last_grant_d;
  logic [WIDE_W-1:0]   a_q, a_d;
  logic [WIDE_W-1:0]   b_q, b_d;
  logic                cin_q, cin_d;
  logic                wide_q, wide_d;
  logic                c_lo_q, c_lo_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [WIDE_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic                rsp_cout_q, rsp_cout_d;
`ifdef ADD_SHARE_FLAGS_EN
  logic                ovf_q, ovf_d;
  logic                zero_q, zero_d;
`endif

  logic [IDW:0]        pick;
  logic                grant_found;
  logic [IDW-1:0]      grant_idx;
  logic                accept;

  logic [ADD_W-1:0]    add_a, add_b, add_sum;
  logic                add_cin, add_cout;

  // Returns {found, index} of the first valid requester after 'last', wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0]   r;
    logic [IDW-1:0] idx;
    r = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last) + k) % NREQ);
      if (!r[IDW] && v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    pick        = rr_pick(req_valid, last_grant_q);
    grant_found = pick[IDW];
    grant_idx   = pick[IDW-1:0];
    accept      = (state_q == IDLE) && !rst && grant_found;
    req_ready   = accept ? (NREQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    if (state_q == HI) begin
      add_a   = a_q[WIDE_W-1:ADD_W];
      add_b   = b_q[WIDE_W-1:ADD_W];
      add_cin = c_lo_q;
    end else begin
      add_a   = a_q[ADD_W-1:0];
      add_b   = b_q[ADD_W-1:0];
      add_cin = cin_q;
    end
  end

  RCA32 u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    wide_d       = wide_q;
    c_lo_d       = c_lo_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
`ifdef ADD_SHARE_FLAGS_EN
    ovf_d        = ovf_q;
    zero_d       = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = req_a[grant_idx*WIDE_W +: WIDE_W];
          b_d          = req_b[grant_idx*WIDE_W +: WIDE_W];
          cin_d        = req_cin[grant_idx];
          wide_d       = req_wide[grant_idx];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = LO;
        end
      end
      LO: begin
        rsp_sum_d[ADD_W-1:0] = add_sum;
        c_lo_d               = add_cout;
        rsp_id_d             = id_q;
        if (wide_q) begin
          state_d = HI;
        end else begin
          rsp_sum_d[WIDE_W-1:ADD_W] = '0;
          rsp_cout_d                = add_cout;
          rsp_valid_d               = 1'b1;
          state_d                   = RSP;
`ifdef ADD_SHARE_FLAGS_EN
          ovf_d  = (a_q[ADD_W-1] == b_q[ADD_W-1]) && (add_sum[ADD_W-1] != a_q[ADD_W-1]);
          zero_d = (add_sum == '0);
`endif
        end
      end
      HI: begin
        rsp_sum_d[WIDE_W-1:ADD_W] = add_sum;
        rsp_cout_d                = add_cout;
        rsp_valid_d               = 1'b1;
        state_d                   = RSP;
`ifdef ADD_SHARE_FLAGS_EN
        // Low half was registered in LO, so zero must look at both halves.
        ovf_d  = (a_q[WIDE_W-1] == b_q[WIDE_W-1]) && (add_sum[ADD_W-1] != a_q[WIDE_W-1]);
        zero_d = (add_sum == '0) && (rsp_sum_q[ADD_W-1:0] == '0);
`endif
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      wide_q       <= 1'b0;
      c_lo_q       <= 1'b0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
`ifdef ADD_SHARE_FLAGS_EN
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      wide_q       <= wide_d;
      c_lo_q       <= c_lo_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
`ifdef ADD_SHARE_FLAGS_EN
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef ADD_SHARE_FLAGS_EN
  assign rsp_ovf   = ovf_q;
  assign rsp_zero  = zero_q;
`endif

endmodule
